// File: rtl/rgals_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rgals_pkg
//  Brief    : Shared widths, checker counter type and sizing helpers for the
//             ratiochronous tick bridge.
//  Revision : 1.0  initial release
// ============================================================================
package rgals_pkg;

    localparam int c_depth_default   = 2;
    localparam int c_src_div_default = 3;
    localparam int c_dst_div_default = 2;

    localparam int c_ptr_w_default = $clog2(c_depth_default);
    localparam int c_cnt_w_default = $clog2(c_depth_default + 1);

    // Checker counter saturates here; every divide ratio must stay below it.
    localparam int c_div_max   = 255;
    localparam int c_div_cnt_w = $clog2(c_div_max + 1);

    typedef logic [c_div_cnt_w-1:0] div_cnt_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgals_tick_checker.sv
`default_nettype none
// ============================================================================
//  Module   : rgals_tick_checker
//  Brief    : Sticky error when a divider tick arrives early or goes missing.
//  Revision : 1.0  initial release
// ============================================================================
module rgals_tick_checker
    import rgals_pkg::*;
#(
    parameter int p_div = 3
) (
    input  logic clk,
    input  logic clk_reset_n,
    input  logic tick,
    output logic err
);

    localparam div_cnt_t c_div = div_cnt_t'(p_div);

    div_cnt_t r_cnt;
    logic     r_armed;
    logic     r_err;

    if ((p_div < 1) || (p_div >= c_div_max)) begin : g_bad_div
        $error("rgals_tick_checker: p_div out of range");
    end

    // r_cnt holds the number of cycles elapsed since the last tick cycle.
    always_ff @(posedge clk or negedge clk_reset_n) begin
        if (!clk_reset_n) begin
            r_cnt   <= '0;
            r_armed <= 1'b0;
            r_err   <= 1'b0;
        end else if (tick) begin
            r_cnt   <= div_cnt_t'(1);
            r_armed <= 1'b1;
            if (r_armed && (r_cnt != c_div)) begin
                r_err <= 1'b1;
            end
        end else begin
            if (r_cnt != '1) begin
                r_cnt <= r_cnt + div_cnt_t'(1);
            end
            if (r_armed && (r_cnt >= c_div)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;

endmodule
`default_nettype wire

// File: rtl/rgals_tick_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : rgals_tick_bridge
//  Brief    : Val/rdy message bridge between two tick-divided clock domains.
//             Define RGALS_TICK_CHECK_EN to build the tick-period checkers.
//  Revision : 1.0  initial release
// ============================================================================
module rgals_tick_bridge
    import rgals_pkg::*;
#(
    parameter int p_nbits   = 32,
    parameter int p_depth   = 2,
    parameter int p_src_div = 3,
    parameter int p_dst_div = 2
) (
    input  logic               clk,
    input  logic               clk_reset_n,
    input  logic               tick_src,
    input  logic               tick_dst,
    input  logic               src_val,
    output logic               src_rdy,
    input  logic [p_nbits-1:0] src_msg,
    output logic               dst_val,
    input  logic               dst_rdy,
    output logic [p_nbits-1:0] dst_msg,
    output logic               tick_err
);

    localparam int                 c_ptr_w = ptr_width(p_depth);
    localparam int                 c_cnt_w = cnt_width(p_depth);
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(p_depth);

    if ((p_depth < 2) || ((p_depth & (p_depth - 1)) != 0)) begin : g_bad_depth
        $error("rgals_tick_bridge: p_depth must be a power of two >= 2");
    end

    if ((p_src_div < 1) || (p_dst_div < 1)) begin : g_bad_div
        $error("rgals_tick_bridge: divide ratios must be >= 1");
    end

    logic [p_nbits-1:0] r_mem [p_depth];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_src_rdy;
    logic               r_dst_val;

    logic               w_push;
    logic               w_pop;
    logic [c_cnt_w-1:0] w_count_next;

    // Handshakes only count on their own domain's tick cycle.
    always_comb begin
        w_push       = tick_src & src_val & r_src_rdy;
        w_pop        = tick_dst & r_dst_val & dst_rdy;
        w_count_next = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    end

    // Flags may go stale between ticks only in the safe direction: count
    // can only fall between source ticks and only rise between destination ticks.
    always_ff @(posedge clk or negedge clk_reset_n) begin
        if (!clk_reset_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_src_rdy <= 1'b0;
            r_dst_val <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= w_count_next;
            if (tick_src) begin
                r_src_rdy <= (w_count_next < c_full);
            end
            if (tick_dst) begin
                r_dst_val <= (w_count_next != '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= src_msg;
        end
    end

    assign src_rdy = r_src_rdy;
    assign dst_val = r_dst_val;
    assign dst_msg = r_mem[r_rd_ptr];

`ifdef RGALS_TICK_CHECK_EN
    logic w_src_err;
    logic w_dst_err;

    rgals_tick_checker #(.p_div(p_src_div)) u_src_chk (
        .clk         (clk),
        .clk_reset_n (clk_reset_n),
        .tick        (tick_src),
        .err         (w_src_err)
    );

    rgals_tick_checker #(.p_div(p_dst_div)) u_dst_chk (
        .clk         (clk),
        .clk_reset_n (clk_reset_n),
        .tick        (tick_dst),
        .err         (w_dst_err)
    );

    assign tick_err = w_src_err | w_dst_err;
`else
    assign tick_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rgals_tick_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rgals_tick_bridge
//  Brief    : Scoreboard bench for rgals_tick_bridge (div 3 / div 2 ticks).
//  Revision : 1.0  initial release
// ============================================================================
module tb_rgals_tick_bridge;

    logic        clk = 1'b0;
    logic        clk_reset_n = 1'b0;
    logic        tick_src = 1'b0;
    logic        tick_dst = 1'b0;
    logic        src_val = 1'b0;
    logic        src_rdy;
    logic [31:0] src_msg = '0;
    logic        dst_val;
    logic        dst_rdy = 1'b0;
    logic [31:0] dst_msg;
    logic        tick_err;

    rgals_tick_bridge #(
        .p_nbits   (32),
        .p_depth   (2),
        .p_src_div (3),
        .p_dst_div (2)
    ) dut (
        .clk         (clk),
        .clk_reset_n (clk_reset_n),
        .tick_src    (tick_src),
        .tick_dst    (tick_dst),
        .src_val     (src_val),
        .src_rdy     (src_rdy),
        .src_msg     (src_msg),
        .dst_val     (dst_val),
        .dst_rdy     (dst_rdy),
        .dst_msg     (dst_msg),
        .tick_err    (tick_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a message queue plus the flag rules from the bridge contract.
    logic [31:0] exp_q[$];
    int          m_count = 0;
    bit          m_src_rdy = 1'b0;
    bit          m_dst_val = 1'b0;
    bit          m_err = 1'b0;
    bit          early_pending = 1'b0;
    bit          m_push;
    bit          m_pop;

    // Driver controls
    int          sc = 0;
    int          dc = 0;
    bit          drv_rand = 1'b0;
    bit          drv_val = 1'b0;
    bit          drv_rdy = 1'b0;
    logic [31:0] drv_msg = '0;
    bit          seq_mode = 1'b0;
    logic [31:0] seq_next = '0;
    bit          inject_early = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            sc = (sc + 1) % 3;
            dc = (dc + 1) % 2;
            if (inject_early && sc == 2) begin
                sc            = 0;
                inject_early  = 1'b0;
                early_pending = 1'b1;
            end
            tick_src = (sc == 0);
            tick_dst = (dc == 0);
            if (drv_rand) begin
                src_val = ($urandom_range(0, 9) < 7);
                src_msg = $urandom;
                dst_rdy = ($urandom_range(0, 9) < 7);
            end else begin
                src_val = drv_val;
                src_msg = seq_mode ? seq_next : drv_msg;
                dst_rdy = drv_rdy;
            end
        end
    endtask

    // Model update at each clock edge, from the inputs of the finishing cycle.
    initial begin
        forever begin
            @(posedge clk or negedge clk_reset_n);
            if (!clk_reset_n) begin
                m_count       = 0;
                m_src_rdy     = 1'b0;
                m_dst_val     = 1'b0;
                m_err         = 1'b0;
                early_pending = 1'b0;
                exp_q.delete();
            end else begin
                m_push = tick_src && src_val && m_src_rdy;
                m_pop  = tick_dst && dst_rdy && m_dst_val;
                if (m_push) begin
                    exp_q.push_back(src_msg);
                    if (seq_mode) seq_next = seq_next + 32'd1;
                end
                m_count = m_count + int'(m_push) - int'(m_pop);
                if (tick_src) m_src_rdy = (m_count < 2);
                if (tick_dst) m_dst_val = (m_count > 0);
`ifdef RGALS_TICK_CHECK_EN
                if (early_pending) m_err = 1'b1;
`endif
                early_pending = 1'b0;
            end
        end
    end

    // Monitor: compare flags every cycle, pop and check data on each delivery.
    initial begin
        forever begin
            @(negedge clk);
            check("src_rdy", {31'b0, src_rdy}, {31'b0, m_src_rdy});
            check("dst_val", {31'b0, dst_val}, {31'b0, m_dst_val});
            check("tick_err", {31'b0, tick_err}, {31'b0, m_err});
            if (clk_reset_n && m_dst_val) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dst_head actual=%h required=<queue empty>", dst_msg);
                end else begin
                    check("dst_head", dst_msg, exp_q[0]);
                    if (tick_dst && dst_rdy) begin
                        check("dst_pop", dst_msg, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset release, idle traffic
        run(3);
        clk_reset_n = 1'b1;
        run(10);
        check("idle_src_rdy", {31'b0, src_rdy}, 32'd1);
        check("idle_dst_val", {31'b0, dst_val}, 32'd0);

        // Single message
        drv_msg = 32'hDEADBEEF;
        drv_val = 1'b1;
        for (int i = 0; i < 10 && m_count == 0; i++) run(1);
        drv_val = 1'b0;
        for (int i = 0; i < 10 && !m_dst_val; i++) run(1);
        check("single_val", {31'b0, dst_val}, 32'd1);
        check("single_msg", dst_msg, 32'hDEADBEEF);
        drv_rdy = 1'b1;
        for (int i = 0; i < 10 && m_dst_val; i++) run(1);
        check("single_drained", {31'b0, dst_val}, 32'd0);

        // Fill with destination stalled: only two of three fit
        seq_mode = 1'b1;
        seq_next = 32'd1;
        drv_rdy  = 1'b0;
        drv_val  = 1'b1;
        run(12);
        check("full_src_rdy", {31'b0, src_rdy}, 32'd0);
        check("full_dst_val", {31'b0, dst_val}, 32'd1);
        check("full_head", dst_msg, 32'd1);
        drv_val = 1'b0;
        drv_rdy = 1'b1;
        run(8);
        check("drain_src_rdy", {31'b0, src_rdy}, 32'd1);
        check("drain_dst_val", {31'b0, dst_val}, 32'd0);
        seq_mode = 1'b0;

        // Randomized traffic, ticks coincide every sixth cycle
        drv_rand = 1'b1;
        run(1500);
        drv_rand = 1'b0;

        // Reset with two entries buffered
        seq_mode = 1'b1;
        seq_next = 32'd100;
        drv_val  = 1'b1;
        drv_rdy  = 1'b0;
        run(12);
        check("prerst_dst_val", {31'b0, dst_val}, 32'd1);
        #2;
        clk_reset_n = 1'b0;
        #1;
        check("rst_src_rdy", {31'b0, src_rdy}, 32'd0);
        check("rst_dst_val", {31'b0, dst_val}, 32'd0);
        drv_val = 1'b0;
        drv_rdy = 1'b1;
        run(1);
        clk_reset_n = 1'b1;
        run(10);
        check("postrst_dst_val", {31'b0, dst_val}, 32'd0);
        check("postrst_src_rdy", {31'b0, src_rdy}, 32'd1);
        seq_mode = 1'b0;

        // One early source tick
        inject_early = 1'b1;
        run(6);
        run(6);
`ifdef RGALS_TICK_CHECK_EN
        check("tick_err_sticky", {31'b0, tick_err}, 32'd1);
`else
        check("tick_err_tied", {31'b0, tick_err}, 32'd0);
`endif
        #2;
        clk_reset_n = 1'b0;
        run(1);
        clk_reset_n = 1'b1;
        run(8);
        check("tick_err_cleared", {31'b0, tick_err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
